// File: rtl/memory_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, read opcodes
// and the latched command that is replayed onto the memory interface.
package memory_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam logic [1:0] OP_BIT  = 2'd0;
    localparam logic [1:0] OP_WORD = 2'd1;
    localparam logic [1:0] OP_BYTE = 2'd2;

    typedef struct packed {
        logic        we;
        logic [1:0]  opcode;
        logic [15:0] addr;
        logic [1:0]  byte_addr;
        logic [4:0]  bit_addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted
// most recently wins. Purely combinational, one-hot (or zero) grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick the single winner; a lone request always wins outright.
    always_comb begin
        // NOTE: gnt gets a value before any branch so no path leaves it unassigned (no latch).
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port
// 32-bit memory. Serialises bit/word/byte reads and word writes, waits out
// the memory read latency and returns read data to the issuing requester.
module memory_arbiter
    import memory_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       req_we,
    input  logic [1:0][1:0]  req_opcode,
    input  logic [1:0][15:0] req_addr,
    input  logic [1:0][1:0]  req_byte_addr,
    input  logic [1:0][4:0]  req_bit_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [31:0]      rdata,
    output logic             mem_WrEn,
    output logic             mem_RdEn,
    output logic [1:0]       mem_RdEn_Opcode,
    output logic [15:0]      mem_Addr,
    output logic [1:0]       mem_ByteAddr,
    output logic [4:0]       mem_BitAddr,
    output logic [31:0]      mem_WrBus,
    input  logic [31:0]      mem_RdBus
);

    localparam logic [2:0] LAT3 = 3'(READ_LAT);

    arb_state_t state;
    mem_cmd_t   cmd;
    mem_cmd_t   winCmd;
    logic       last;
    logic       owner;
    logic       winner;
    logic [2:0] waitCnt;
    logic [1:0] arbGnt;

    rr_arbiter2 uArb (
        .req  (req),
        .last (last),
        .gnt  (arbGnt)
    );

    // Grants are offered only while idle and out of reset.
    assign gnt    = (state == IDLE && !reset) ? arbGnt : 2'b00;
    assign winner = arbGnt[1];

    // The latched command holds between transactions, so the memory bus keeps its last values.
    assign mem_RdEn_Opcode = cmd.opcode;
    assign mem_Addr        = cmd.addr;
    assign mem_ByteAddr    = cmd.byte_addr;
    assign mem_BitAddr     = cmd.bit_addr;
    assign mem_WrBus       = cmd.wdata;

    // Gather the winning requester's fields into one command word.
    always_comb begin
        winCmd = '{
            we:        req_we[winner],
            opcode:    req_opcode[winner],
            addr:      req_addr[winner],
            byte_addr: req_byte_addr[winner],
            bit_addr:  req_bit_addr[winner],
            wdata:     req_wdata[winner]
        };
    end

    // Sequencer FSM with registered strobes, read capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            last     <= 1'b1;
            owner    <= 1'b0;
            waitCnt  <= '0;
            mem_WrEn <= 1'b0;
            mem_RdEn <= 1'b0;
            rvalid   <= 2'b00;
            // NOTE: rdata is cleared on reset so a read dropped by reset never leaks stale data.
            rdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments here; the defaults below are overridden later in the same block.
            mem_WrEn <= 1'b0;
            mem_RdEn <= 1'b0;
            rvalid   <= 2'b00;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        cmd      <= winCmd;
                        owner    <= winner;
                        last     <= winner;
                        mem_WrEn <= winCmd.we;
                        mem_RdEn <= !winCmd.we;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd.we) begin
                        state <= IDLE;
                    end else begin
                        waitCnt <= 3'd1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == LAT3) begin
                        rdata         <= mem_RdBus;
                        rvalid[owner] <= 1'b1;
                        waitCnt       <= '0;
                        state         <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: two instances (READ_LAT 1 and 3),
// each with a behavioural memory, and a scoreboard of expected read returns.
module tb_memory_arbiter;
    import memory_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    logic             resetSig    [2];
    logic [1:0]       req         [2];
    logic [1:0]       reqWe       [2];
    logic [1:0][1:0]  reqOpcode   [2];
    logic [1:0][15:0] reqAddr     [2];
    logic [1:0][1:0]  reqByteAddr [2];
    logic [1:0][4:0]  reqBitAddr  [2];
    logic [1:0][31:0] reqWdata    [2];
    logic [1:0]       gnt         [2];
    logic [1:0]       rvalid      [2];
    logic [31:0]      rdata       [2];
    logic             memWrEn     [2];
    logic             memRdEn     [2];
    logic [1:0]       memOpcode   [2];
    logic [15:0]      memAddr     [2];
    logic [1:0]       memByteAddr [2];
    logic [4:0]       memBitAddr  [2];
    logic [31:0]      memWrBus    [2];

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   refLast [2];

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] readModel(input logic [31:0] word, input logic [1:0] op,
                                              input logic [1:0] ba, input logic [4:0] bi);
        case (op)
            OP_BIT:  return {31'b0, word[bi]};
            OP_BYTE: return {24'b0, word[8*ba +: 8]};
            default: return word;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [31:0] memArr [0:255];
        logic [31:0] rdBuf = 32'h0;
        int          validCycle = -100;
        logic [31:0] memRdBus;
        exp_t        e;

        assign memRdBus = (cycleCnt == validCycle) ? rdBuf : 32'hBAD0_BAD0;

        // Behavioural memory: data valid only in the cycle READ_LAT after RdEn.
        always @(posedge clk) begin
            if (memWrEn[k]) memArr[memAddr[k][7:0]] <= memWrBus[k];
            if (memRdEn[k]) begin
                validCycle <= cycleCnt + LAT;
                rdBuf      <= readModel(memArr[memAddr[k][7:0]], memOpcode[k],
                                        memByteAddr[k], memBitAddr[k]);
            end
        end

        memory_arbiter #(.READ_LAT(LAT)) dut (
            .clk             (clk),
            .reset           (resetSig[k]),
            .req             (req[k]),
            .req_we          (reqWe[k]),
            .req_opcode      (reqOpcode[k]),
            .req_addr        (reqAddr[k]),
            .req_byte_addr   (reqByteAddr[k]),
            .req_bit_addr    (reqBitAddr[k]),
            .req_wdata       (reqWdata[k]),
            .gnt             (gnt[k]),
            .rvalid          (rvalid[k]),
            .rdata           (rdata[k]),
            .mem_WrEn        (memWrEn[k]),
            .mem_RdEn        (memRdEn[k]),
            .mem_RdEn_Opcode (memOpcode[k]),
            .mem_Addr        (memAddr[k]),
            .mem_ByteAddr    (memByteAddr[k]),
            .mem_BitAddr     (memBitAddr[k]),
            .mem_WrBus       (memWrBus[k]),
            .mem_RdBus       (memRdBus)
        );

        // Scoreboard consumer and grant one-hot monitor.
        always @(negedge clk) begin
            if (gnt[k] !== 2'b00) check($sformatf("gnt_onehot_i%0d", k), {31'b0, $onehot(gnt[k])}, 32'd1);
            if (rvalid[k] !== 2'b00) begin
                if (sbQ.size() == 0 || sbQ[0].inst != k) begin
                    check($sformatf("spurious_rvalid_i%0d", k), {30'b0, rvalid[k]}, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    check($sformatf("rvalid_port_i%0d", k), {30'b0, rvalid[k]}, 32'd1 << e.port);
                    check($sformatf("rdata_i%0d_p%0d", k, e.port), rdata[k], e.data);
                    check($sformatf("rvalid_cycle_i%0d", k), cycleCnt, e.cyc);
                end
            end
        end
    end

    task automatic issue(input int k, input int p, input logic we, input logic [1:0] op,
                         input logic [15:0] addr, input logic [1:0] ba, input logic [4:0] bi,
                         input logic [31:0] wd, input logic [31:0] expData, input bit track);
        int n = 0;
        reqWe[k][p]       = we;
        reqOpcode[k][p]   = op;
        reqAddr[k][p]     = addr;
        reqByteAddr[k][p] = ba;
        reqBitAddr[k][p]  = bi;
        reqWdata[k][p]    = wd;
        req[k][p]         = 1'b1;
        #1;
        while (!gnt[k][p] && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("grant_i%0d_p%0d", k, p), {31'b0, gnt[k][p]}, 32'd1);
        if (gnt[k][p]) begin
            refLast[k] = p;
            if (!we && track)
                sbQ.push_back('{inst: k, port: p, data: expData, cyc: cycleCnt + 2 + latOf(k)});
        end
        @(negedge clk);
        req[k][p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", sbQ.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          w;
        logic [31:0] portData [2];

        refLast = '{1, 1};
        for (int k = 0; k < 2; k++) begin
            resetSig[k] = 1'b1;
            req[k] = '0; reqWe[k] = '0; reqOpcode[k] = '0; reqAddr[k] = '0;
            reqByteAddr[k] = '0; reqBitAddr[k] = '0; reqWdata[k] = '0;
        end
        // Both requesters hold writes across reset.
        reqWe[0]    = 2'b11;
        reqAddr[0]  = {16'h0020, 16'h1234};
        reqWdata[0] = {32'hCAFE_0001, 32'hDEAD_BEEF};
        req[0]      = 2'b11;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_gnt_i%0d", k), {30'b0, gnt[k]}, 32'd0);
            check($sformatf("rst_rvalid_i%0d", k), {30'b0, rvalid[k]}, 32'd0);
            check($sformatf("rst_rdata_i%0d", k), rdata[k], 32'd0);
            check($sformatf("rst_wren_i%0d", k), {31'b0, memWrEn[k]}, 32'd0);
            check($sformatf("rst_rden_i%0d", k), {31'b0, memRdEn[k]}, 32'd0);
            check($sformatf("rst_addr_i%0d", k), {16'b0, memAddr[k]}, 32'd0);
            check($sformatf("rst_wrbus_i%0d", k), memWrBus[k], 32'd0);
        end
        @(negedge clk);
        check("gnt_during_reset", {30'b0, gnt[0]}, 32'd0);
        resetSig[0] = 1'b0;
        resetSig[1] = 1'b0;
        #1;
        check("first_tie_gnt", {30'b0, gnt[0]}, 32'b01);
        refLast[0] = 0;
        @(negedge clk);
        req[0][0] = 1'b0;
        check("wr_issue_wren", {31'b0, memWrEn[0]}, 32'd1);
        check("wr_issue_rden", {31'b0, memRdEn[0]}, 32'd0);
        check("wr_issue_addr", {16'b0, memAddr[0]}, 32'h1234);
        check("wr_issue_wrbus", memWrBus[0], 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_wren_single_cycle", {31'b0, memWrEn[0]}, 32'd0);
        check("wr_regrant_cycle2", {30'b0, gnt[0]}, 32'b10);
        refLast[0] = 1;
        @(negedge clk);
        req[0][1] = 1'b0;

        // Word, byte and bit reads of the same address from port 0.
        issue(0, 0, 1'b0, OP_WORD, 16'h1234, 2'd0, 5'd0, 32'd0, 32'hDEAD_BEEF, 1'b1);
        drain();
        issue(0, 0, 1'b0, OP_BYTE, 16'h1234, 2'd3, 5'd0, 32'd0, 32'h0000_00DE, 1'b1);
        drain();
        issue(0, 0, 1'b0, OP_BIT, 16'h1234, 2'd0, 5'd5, 32'd0, 32'h0000_0001, 1'b1);
        drain();
        issue(0, 1, 1'b1, OP_WORD, 16'h0020, 2'd0, 5'd0, 32'h0BAD_F00D, 32'd0, 1'b1);

        // Continuous contention: both ports hold word reads for 8 grants.
        portData[0] = 32'hDEAD_BEEF;
        portData[1] = 32'h0BAD_F00D;
        reqWe[0]     = 2'b00;
        reqOpcode[0] = {OP_WORD, OP_WORD};
        reqAddr[0]   = {16'h0020, 16'h1234};
        req[0]       = 2'b11;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            #1;
            while (gnt[0] == 2'b00 && n < 40) begin
                @(negedge clk); #1;
                n++;
            end
            w = 1 - refLast[0];
            check($sformatf("rr_order_%0d", t), {30'b0, gnt[0]}, 32'd1 << w);
            refLast[0] = w;
            sbQ.push_back('{inst: 0, port: w, data: portData[w], cyc: cycleCnt + 3});
            @(negedge clk);
        end
        req[0] = 2'b00;
        drain();

        // READ_LAT = 3 instance.
        issue(1, 0, 1'b1, OP_WORD, 16'h0040, 2'd0, 5'd0, 32'h55AA_33CC, 32'd0, 1'b1);
        issue(1, 0, 1'b0, OP_WORD, 16'h0040, 2'd0, 5'd0, 32'd0, 32'h55AA_33CC, 1'b1);
        check("lat3_rden_c1", {31'b0, memRdEn[1]}, 32'd1);
        @(negedge clk);
        check("lat3_rden_c2", {31'b0, memRdEn[1]}, 32'd0);
        drain();

        // Reset while a port 1 read sits in WAIT: the read is dropped.
        issue(1, 1, 1'b0, OP_WORD, 16'h0040, 2'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        resetSig[1] = 1'b1;
        @(negedge clk);
        resetSig[1] = 1'b0;
        refLast[1]  = 1;
        check("rst_wait_rdata", rdata[1], 32'd0);
        repeat (6) @(negedge clk);
        check("rst_wait_no_rvalid", {30'b0, rvalid[1]}, 32'd0);
        issue(1, 1, 1'b0, OP_WORD, 16'h0040, 2'd0, 5'd0, 32'd0, 32'h55AA_33CC, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
